// File: rtl/ercd8_div.sv
// Unsigned 16/8 restoring divider with a valid/ready handshake on both sides.
// Optional macro ERCD8_TRUNC_EN adds a trunc port that skips LSB quotient bits.
module ercd8_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [15:0] dat_in_a,
    input  logic [7:0]  dat_in_b,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [7:0]  dat_o_q,
    output logic [7:0]  dat_o_r,
    output logic        dat_o_err
`ifdef ERCD8_TRUNC_EN
    ,
    input  logic [2:0]  trunc
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [8:0]  rem;
    logic [7:0]  dvd_lo;
    logic [7:0]  dvs;
    logic [6:0]  quo;
    logic [3:0]  cnt;
    logic [2:0]  trunc_r;
    logic [2:0]  trunc_in;

    logic [9:0]  trial;
    logic        q_bit;
    logic [8:0]  rem_nxt;
    logic [7:0]  quo_nxt;

`ifdef ERCD8_TRUNC_EN
    assign trunc_in = trunc;
`else
    assign trunc_in = 3'd0;
`endif

    assign in_rdy  = (state == IDLE) && !rst;
    assign out_vld = (state == DONE);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        trial   = {rem, dvd_lo[7]};
        q_bit   = (trial >= {2'b00, dvs});
        rem_nxt = q_bit ? 9'(trial - {2'b00, dvs}) : trial[8:0];
        quo_nxt = {quo, q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            dvd_lo    <= '0;
            dvs       <= '0;
            quo       <= '0;
            cnt       <= '0;
            trunc_r   <= '0;
            dat_o_q   <= '0;
            dat_o_r   <= '0;
            dat_o_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        dvs     <= dat_in_b;
                        dvd_lo  <= dat_in_a[7:0];
                        rem     <= {1'b0, dat_in_a[15:8]};
                        quo     <= '0;
                        trunc_r <= trunc_in;
                        // A high byte not below the divisor cannot yield an 8-bit quotient.
                        if (dat_in_a[15:8] >= dat_in_b) begin
                            state     <= DONE;
                            dat_o_q   <= 8'hFF;
                            dat_o_r   <= 8'h00;
                            dat_o_err <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= 4'd8 - {1'b0, trunc_in};
                        end
                    end
                end
                CALC: begin
                    rem    <= rem_nxt;
                    quo    <= quo_nxt[6:0];
                    dvd_lo <= {dvd_lo[6:0], 1'b0};
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= DONE;
                        dat_o_q   <= quo_nxt << trunc_r;
                        dat_o_r   <= (trunc_r == 3'd0) ? rem_nxt[7:0] : 8'h00;
                        dat_o_err <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ercd8_div.sv
// Self-checking bench for ercd8_div: directed, random and handshake scenarios
// compared against an arithmetic reference model.
module tb_ercd8_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] a;
    logic [7:0]  b;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        err;
    logic [2:0]  trunc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ercd8_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .dat_in_a  (a),
        .dat_in_b  (b),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .dat_o_q   (q),
        .dat_o_r   (r),
        .dat_o_err (err)
`ifdef ERCD8_TRUNC_EN
        ,
        .trunc     (trunc)
`endif
    );

    // Expected result and acceptance-to-out_vld latency in clock edges.
    function automatic void model(input logic [15:0] ma, input logic [7:0] mb, input int t,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic ee, output int elat);
        int qq;
        if (mb == 8'd0 || (int'(ma) / 256) >= int'(mb)) begin
            eq = 8'hFF; er = 8'h00; ee = 1'b1; elat = 0;
        end else begin
            qq   = int'(ma) / int'(mb);
            eq   = 8'((qq >> t) << t);
            er   = (t == 0) ? 8'(int'(ma) % int'(mb)) : 8'h00;
            ee   = 1'b0;
            elat = 8 - t;
        end
    endfunction

    task automatic do_op(input logic [15:0] oa, input logic [7:0] ob, input logic [2:0] ot,
                         output logic [7:0] oq, output logic [7:0] orr, output logic oe,
                         output int lat, output logic post_vld, output logic post_rdy,
                         output logic timed_out);
        int w;
        timed_out = 1'b0; lat = 0; post_vld = 1'b0; post_rdy = 1'b0;
        oq = 8'h00; orr = 8'h00; oe = 1'b0;
        w = 0;
        while (!in_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_rdy) begin
            timed_out = 1'b1;
            return;
        end
        a = oa; b = ob; trunc = ot; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        a = 16'($urandom); b = 8'($urandom); trunc = 3'($urandom_range(0, 7));
        while (!out_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_vld) begin
            timed_out = 1'b1;
            return;
        end
        oq = q; orr = r; oe = err;
        @(negedge clk);
        post_vld = out_vld;
        post_rdy = in_rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; out_rdy = 1'b1; a = 16'd1000; b = 8'd7; trunc = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_rdy: got %b expected 0", in_rdy);
        end
        checks++;
        if (out_vld !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_vld: got %b expected 0", out_vld);
        end
        checks++;
        if ({q, r, err} !== 17'd0) begin
            errors++; $display("[TB] FAIL reset_outputs: got q=%h r=%h err=%b expected zeros", q, r, err);
        end
        rst = 1'b0; in_vld = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_release_in_rdy: got %b expected 1", in_rdy);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4] = '{16'd1000, 16'd5, 16'h0700, 16'h06FF};
        logic [7:0]  tb_ [4] = '{8'd7, 8'd0, 8'd7, 8'd7};
        logic [7:0]  xq [4] = '{8'd142, 8'hFF, 8'hFF, 8'd255};
        logic [7:0]  xr [4] = '{8'd6, 8'h00, 8'h00, 8'd6};
        logic        xe [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          xl [4] = '{8, 0, 0, 8};
        logic [7:0] oq, orr; logic oe, pv, pr, to; int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb_[i], 3'd0, oq, orr, oe, lat, pv, pr, to);
            checks++;
            if (to || oq !== xq[i] || orr !== xr[i] || oe !== xe[i]) begin
                errors++;
                $display("[TB] FAIL directed_result[%0d]: got q=%0d r=%0d err=%b timeout=%b expected q=%0d r=%0d err=%b",
                         i, oq, orr, oe, to, xq[i], xr[i], xe[i]);
            end
            checks++;
            if (lat != xl[i] || pv !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_timing[%0d]: got latency=%0d vld_after=%b expected latency=%0d vld_after=0",
                         i, lat, pv, xl[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra; logic [7:0] rb; logic [2:0] rt;
        logic [7:0] oq, orr, eq, er; logic oe, ee, pv, pr, to; int lat, elat;
        for (int i = 0; i < 30; i++) begin
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'd0 || $urandom_range(0, 7) == 0)
                ra = 16'($urandom);
            else
                ra = 16'($urandom_range(0, int'(rb) * 256 - 1));
`ifdef ERCD8_TRUNC_EN
            rt = 3'($urandom_range(0, 7));
`else
            rt = 3'd0;
`endif
            model(ra, rb, int'(rt), eq, er, ee, elat);
            do_op(ra, rb, rt, oq, orr, oe, lat, pv, pr, to);
            checks++;
            if (to || oq !== eq || orr !== er || oe !== ee || lat != elat) begin
                errors++;
                $display("[TB] FAIL random[%0d] a=%0d b=%0d t=%0d: got q=%0d r=%0d err=%b lat=%0d to=%b expected q=%0d r=%0d err=%b lat=%0d",
                         i, ra, rb, rt, oq, orr, oe, lat, to, eq, er, ee, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra; logic [7:0] rb;
        logic [7:0] oq, orr, eq, er; logic oe, ee, pv, pr, to; int lat, elat;
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(1, 255));
            ra = 16'($urandom_range(0, int'(rb) * 256 - 1));
            model(ra, rb, 0, eq, er, ee, elat);
            do_op(ra, rb, 3'd0, oq, orr, oe, lat, pv, pr, to);
            checks++;
            if (to || oq !== eq || orr !== er || oe !== ee) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d]: got q=%0d r=%0d err=%b expected q=%0d r=%0d err=%b",
                         i, oq, orr, oe, eq, er, ee);
            end
            checks++;
            if (pv !== 1'b0 || pr !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_handshake[%0d]: got out_vld=%b in_rdy=%b expected out_vld=0 in_rdy=1",
                         i, pv, pr);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        a = 16'd1000; b = 8'd7; trunc = 3'd0; in_vld = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b0;
        w = 0;
        while (!out_vld && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!out_vld) begin
            errors++; $display("[TB] FAIL bp_wait: got out_vld=0 after %0d cycles expected 1", w);
        end
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1; a = 16'h0500 + 16'(i); b = 8'd9;
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || in_rdy !== 1'b0 || q !== 8'd142 || r !== 8'd6 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%0d r=%0d err=%b expected vld=1 rdy=0 q=142 r=6 err=0",
                         i, out_vld, in_rdy, q, r, err);
            end
        end
        out_rdy = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release: got vld=%b rdy=%b expected vld=0 rdy=1", out_vld, in_rdy);
        end
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1 || q !== 8'd142 || r !== 8'd6 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_retain: got rdy=%b q=%0d r=%0d err=%b expected rdy=1 q=142 r=6 err=0",
                               in_rdy, q, r, err);
        end
    endtask

    task automatic test_abort();
        int seen;
        a = 16'd1000; b = 8'd7; trunc = 3'd0; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || {q, r, err} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL abort_state: got rdy=%b vld=%b q=%h r=%h err=%b expected rdy=1 vld=0 zeros",
                     in_rdy, out_vld, q, r, err);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_vld === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("[TB] FAIL abort_no_result: got %0d out_vld cycles expected 0", seen);
        end
    endtask

`ifdef ERCD8_TRUNC_EN
    task automatic test_trunc();
        logic [2:0] tt [3] = '{3'd3, 3'd0, 3'd7};
        logic [7:0] oq, orr, eq, er; logic oe, ee, pv, pr, to; int lat, elat;
        for (int i = 0; i < 3; i++) begin
            model(16'd1000, 8'd7, int'(tt[i]), eq, er, ee, elat);
            do_op(16'd1000, 8'd7, tt[i], oq, orr, oe, lat, pv, pr, to);
            checks++;
            if (to || oq !== eq || orr !== er || oe !== ee || lat != elat) begin
                errors++;
                $display("[TB] FAIL trunc[%0d]: got q=%0d r=%0d err=%b lat=%0d expected q=%0d r=%0d err=%b lat=%0d",
                         tt[i], oq, orr, oe, lat, eq, er, ee, elat);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_random();
`ifdef ERCD8_TRUNC_EN
        test_trunc();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
